dot_product_sequencer: RTL and testbench

//  Top-level sequencer for the dotProduct datapath (memory controller + SRAMs + PEGroup).

---
 rtl/dot_product_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_dot_product_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Control sequencer for the dotProduct datapath (memory controller, SRAMs, PEGroup).
//   Runs a multi-pass accumulated dot product. Pass 0 writes raw products and later
//   passes add to the stored output (load_old_output=1).
//
// Ports
//   clk, reset            clock (rising edge) and asynchronous active-high reset
//   start, num_passes     host job request; num_passes latched when start is accepted
//   abort                 synchronous job cancel, honoured in any non-idle state
//   state                 datapath step counter, compared against step_cnt only with the
//                         optional check enabled
//   Mem_reset, Comp_reset, PE_reset, Computing, load_old_output
//                         datapath controls
//   busy, done, pass_idx  host status; done is a single-cycle pulse
//   seq_err               sticky step mismatch flag
//
// Optional feature: define DOTP_SEQ_STATE_CHECK_EN to enable the datapath step check.
// Without it, seq_err is tied low and state is ignored.
module dot_product_sequencer #(
    parameter int unsigned bits_Computation = 4,
    parameter int unsigned Nums_Computation = 1 << bits_Computation,
    parameter int unsigned Pass_Width       = 4,
    parameter int unsigned Drain_Cycles     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [Pass_Width-1:0]       num_passes,
    input  logic [bits_Computation-1:0] state,
    output logic                        Mem_reset,
    output logic                        Comp_reset,
    output logic                        Computing,
    output logic                        PE_reset,
    output logic                        load_old_output,
    output logic                        busy,
    output logic                        done,
    output logic [Pass_Width-1:0]       pass_idx,
    output logic                        seq_err
);

    localparam int unsigned DrainW = (Drain_Cycles > 1) ? $clog2(Drain_Cycles) : 1;
    localparam logic [bits_Computation-1:0] StepLast  = bits_Computation'(Nums_Computation - 1);
    localparam logic [bits_Computation-1:0] StepOne   = bits_Computation'(1);
    localparam logic [DrainW-1:0]           DrainLast = DrainW'(Drain_Cycles - 1);
    localparam logic [DrainW-1:0]           DrainOne  = DrainW'(1);
    localparam logic [Pass_Width-1:0]       PassOne   = Pass_Width'(1);

    typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StNext, StDone} st_e;

    st_e                         st_d, st_q;
    logic [bits_Computation-1:0] step_d, step_q;
    logic [DrainW-1:0]           drain_d, drain_q;
    logic [Pass_Width-1:0]       np_d, np_q;
    logic [Pass_Width-1:0]       pass_d, pass_q;
    logic mem_reset_d, mem_reset_q, comp_reset_d, comp_reset_q, pe_reset_d, pe_reset_q;
    logic computing_d, computing_q, load_d, load_q, busy_d, busy_q, done_d, done_q;
    logic start_ok;

    assign start_ok = (st_q == StIdle) && start && (num_passes != '0);

    always_comb begin
        st_d    = st_q;
        step_d  = step_q;
        drain_d = drain_q;
        np_d    = np_q;
        pass_d  = pass_q;
        unique case (st_q)
            StIdle: begin
                if (start_ok) begin
                    np_d   = num_passes;
                    pass_d = '0;
                    st_d   = StClear;
                end
            end
            StClear: begin
                step_d = '0;
                st_d   = StRun;
            end
            StRun: begin
                if (step_q == StepLast) begin
                    step_d  = '0;
                    drain_d = '0;
                    st_d    = StDrain;
                end else begin
                    step_d = step_q + StepOne;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    st_d = (pass_q == np_q - PassOne) ? StDone : StNext;
                end else begin
                    drain_d = drain_q + DrainOne;
                end
            end
            StNext: begin
                pass_d = pass_q + PassOne;
                step_d = '0;
                st_d   = StRun;
            end
            StDone: st_d = StIdle;
            default: st_d = StIdle;
        endcase

        // Abort overrides every transition out of a busy state.
        if (st_q != StIdle && abort) begin
            st_d    = StIdle;
            step_d  = '0;
            drain_d = '0;
        end
        if (st_d == StIdle) begin
            pass_d = '0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        mem_reset_d  = (st_d == StClear);
        pe_reset_d   = (st_d == StClear);
        comp_reset_d = (st_d == StClear) || (st_d == StNext);
        computing_d  = (st_d == StRun);
        load_d       = ((st_d == StRun) || (st_d == StDrain)) && (pass_d != '0);
        busy_d       = (st_d == StClear) || (st_d == StRun) || (st_d == StDrain) ||
                       (st_d == StNext);
        // A zero-pass request completes immediately without leaving idle.
        done_d       = (st_d == StDone) ||
                       ((st_q == StIdle) && start && (num_passes == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q         <= StIdle;
            step_q       <= '0;
            drain_q      <= '0;
            np_q         <= '0;
            pass_q       <= '0;
            mem_reset_q  <= 1'b0;
            comp_reset_q <= 1'b0;
            pe_reset_q   <= 1'b0;
            computing_q  <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            st_q         <= st_d;
            step_q       <= step_d;
            drain_q      <= drain_d;
            np_q         <= np_d;
            pass_q       <= pass_d;
            mem_reset_q  <= mem_reset_d;
            comp_reset_q <= comp_reset_d;
            pe_reset_q   <= pe_reset_d;
            computing_q  <= computing_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign Mem_reset       = mem_reset_q;
    assign Comp_reset      = comp_reset_q;
    assign PE_reset        = pe_reset_q;
    assign Computing       = computing_q;
    assign load_old_output = load_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass_idx        = pass_q;

`ifdef DOTP_SEQ_STATE_CHECK_EN
    logic seq_err_d, seq_err_q;

    // The datapath counter trails step_cnt by one cycle, so step 0 has nothing to compare.
    always_comb begin
        seq_err_d = seq_err_q;
        if (start_ok) begin
            seq_err_d = 1'b0;
        end else if (st_q == StRun && step_q != '0 && state != step_q - StepOne) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    logic unused_state;
    assign unused_state = ^state;
    assign seq_err      = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_sequencer.sv
module tb_dot_product_sequencer;

    localparam int BC = 4;
    localparam int N  = 1 << BC;
    localparam int PW = 4;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [PW-1:0] num_passes;
    logic [BC-1:0] state;
    logic          Mem_reset, Comp_reset, Computing, PE_reset, load_old_output;
    logic          busy, done, seq_err;
    logic [PW-1:0] pass_idx;

    dot_product_sequencer #(
        .bits_Computation(BC),
        .Nums_Computation(N),
        .Pass_Width      (PW),
        .Drain_Cycles    (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .num_passes     (num_passes),
        .state          (state),
        .Mem_reset      (Mem_reset),
        .Comp_reset     (Comp_reset),
        .Computing      (Computing),
        .PE_reset       (PE_reset),
        .load_old_output(load_old_output),
        .busy           (busy),
        .done           (done),
        .pass_idx       (pass_idx),
        .seq_err        (seq_err)
    );

    always #5 clk = ~clk;

    // One expected cycle: ctl = {Mem_reset, Comp_reset, PE_reset, Computing, load, busy, done}.
    // pass < 0 means pass_idx is not checked; step >= 0 marks a compute cycle.
    typedef struct {
        logic [6:0] ctl;
        int         pass;
        int         step;
    } cyc_t;

    int   total = 0;
    int   bad   = 0;
    logic seq_exp = 1'b0;
    logic seq_nxt = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_ctl();
        return {Mem_reset, Comp_reset, PE_reset, Computing, load_old_output, busy, done};
    endfunction

    // Expected schedule for a job of p passes, starting the cycle after start.
    function automatic void build(input int p, output cyc_t q[$]);
        q = {};
        if (p == 0) begin
            q.push_back('{7'b0000001, -1, -1});
        end else begin
            q.push_back('{7'b1110010, 0, -1});
            for (int pp = 0; pp < p; pp++) begin
                logic ld;
                ld = (pp != 0);
                for (int k = 0; k < N; k++) q.push_back('{{4'b0001, ld, 2'b10}, pp, k});
                for (int d = 0; d < D; d++) q.push_back('{{4'b0000, ld, 2'b10}, pp, -1});
                if (pp < p - 1) q.push_back('{7'b0100010, -1, -1});
            end
            q.push_back('{7'b0000001, -1, -1});
        end
        q.push_back('{7'b0000000, 0, -1});
    endfunction

    task automatic run_job(input int p, input int abort_at, input bit abort_with_start,
                           input bit stuck, input bit disturb, input int rst_at);
        cyc_t q[$];
        int   done_seen;
        build(p, q);
        done_seen = -1;
        start      = 1'b1;
        num_passes = PW'(p);
        abort      = abort_with_start;
        state      = BC'($urandom);
        seq_nxt    = (p != 0) ? 1'b0 : seq_exp;
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            seq_exp = seq_nxt;
            check_eq($sformatf("ctl[p%0d c%0d]", p, i + 1), dut_ctl(), q[i].ctl);
            if (q[i].pass >= 0) check_eq($sformatf("pass_idx[c%0d]", i + 1), pass_idx, q[i].pass);
            check_eq($sformatf("seq_err[c%0d]", i + 1), seq_err, seq_exp);
            if (done && done_seen < 0) done_seen = i + 1;

            if (i == rst_at) begin
                start = 1'b0;
                abort = 1'b0;
                reset = 1'b1;
                #1;
                check_eq("rst_async_ctl", dut_ctl(), 7'b0);
                check_eq("rst_async_pass", pass_idx, 0);
                check_eq("rst_async_seq", seq_err, 0);
                @(posedge clk);
                #1;
                reset   = 1'b0;
                seq_exp = 1'b0;
                seq_nxt = 1'b0;
                @(posedge clk);
                #1;
                check_eq("rst_idle_ctl", dut_ctl(), 7'b0);
                return;
            end

            start      = (disturb && q[i].ctl != 7'b0) ? 1'($urandom) : 1'b0;
            num_passes = disturb ? PW'($urandom) : PW'(p);
            abort      = (i == abort_at);
            if (q[i].step >= 0) begin
                if (stuck) state = BC'(3);
                else if (q[i].step == 0) state = BC'($urandom);
                else state = BC'(q[i].step - 1);
            end else begin
                state = BC'($urandom);
            end
`ifdef DOTP_SEQ_STATE_CHECK_EN
            if (q[i].step >= 1 && int'(state) != q[i].step - 1) seq_nxt = 1'b1;
`endif

            if (i == abort_at) begin
                @(posedge clk);
                #1;
                abort = 1'b0;
                start = 1'b0;
                seq_exp = seq_nxt;
                check_eq("abort_ctl", dut_ctl(), 7'b0);
                check_eq("abort_pass", pass_idx, 0);
                check_eq("abort_seq", seq_err, seq_exp);
                return;
            end
        end
        start = 1'b0;
        check_eq($sformatf("latency[p%0d]", p), done_seen,
                 (p == 0) ? 1 : 1 + p * (N + D) + (p - 1) + 1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        num_passes = '0;
        state      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ctl", dut_ctl(), 7'b0);
        check_eq("reset_pass", pass_idx, 0);
        check_eq("reset_seq", seq_err, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_job(1, -1, 0, 0, 0, -1);
        run_job(3, -1, 0, 0, 0, -1);
        run_job(0, -1, 0, 0, 0, -1);
        // Abort at RUN step 5 of pass 1, then a fresh job.
        run_job(3, 1 + N + D + 1 + 5, 0, 0, 0, -1);
        run_job(2, -1, 0, 0, 0, -1);
        // Start wins over abort in idle.
        run_job(2, -1, 1, 0, 0, -1);
        // Re-pulsed start and changing num_passes, then reset in first DRAIN cycle.
        run_job(2, -1, 0, 0, 1, 1 + N);
        // Stuck datapath counter; next start clears the flag.
        run_job(2, -1, 0, 1, 0, -1);
        run_job(0, -1, 0, 0, 0, -1);
        run_job(1, -1, 0, 0, 0, -1);
        run_job(15, -1, 0, 0, 0, -1);
        for (int j = 0; j < 4; j++) begin
            int p;
            int ab;
            p  = int'($urandom_range(1, 4));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1 + p * (N + D))) : -1;
            run_job(p, ab, 0, 0, 1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
